// File: rtl/gt_seq_pkg.sv
// Package: gt_seq_pkg
// Shared types and constants for the GT lane bring-up sequencer.
//  - gt_seq_state_e : 3-bit FSM state encoding, also exported on state_o for debug.
//  - LB_*           : GT loopback mode encodings driven on gt_loopback.
//  - max_int        : helper used to size the shared timer from the largest interval.
package gt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_WAIT_UP    = 3'd3,
    ST_LINK_UP    = 3'd4,
    ST_BACKOFF    = 3'd5,
    ST_FAULT      = 3'd6
  } gt_seq_state_e;

  localparam logic [2:0] LB_NORMAL   = 3'b000;
  localparam logic [2:0] LB_NEAR_PCS = 3'b001;
  localparam logic [2:0] LB_NEAR_PMA = 3'b010;
  localparam logic [2:0] LB_FAR_PMA  = 3'b100;
  localparam logic [2:0] LB_FAR_PCS  = 3'b110;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Module: sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//  clk   in  1  destination clock
//  rst_n in  1  async active-low reset; both flops clear to 0
//  d     in  1  asynchronous input
//  q     out 1  synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so meta and q
  // both sample their pre-edge values; blocking here would collapse the
  // chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gt_link_sequencer.sv
// Module: gt_link_sequencer
// Bring-up controller for one GT lane wrapper, entirely in the init_clk domain.
// Holds the GT in reset, releases it, waits for alignment and link-up with
// timeouts, retries with backoff after failures, declares link_up, and
// re-initialises on loss of link or on a loopback reconfiguration.
//
// Optional feature macro: GT_SEQ_STATS_EN
//  defined   -> adds stat_clr (in) and link_drop_cnt[15:0] (out), a saturating
//               count of link losses (reconfigurations are not counted).
//  undefined -> those ports and the counter do not exist.
//
// Ports:
//  init_clk      in  1  free-running clock
//  rst_n         in  1  async active-low reset
//  enable        in  1  1 = bring link up, 0 = hold GT in reset / clear fault
//  cfg_loopback  in  3  requested GT loopback mode
//  rx_aligned    in  1  GT alignment status (asynchronous)
//  rx_up         in  1  GT link status (asynchronous)
//  gt_rst        out 1  GT wrapper reset, registered
//  gt_loopback   out 3  GT loopback select, registered
//  link_up       out 1  high only in LINK_UP
//  fault         out 1  high only in FAULT
//  retry_cnt     out 4  consecutive failed attempts in the current bring-up
//  state_o       out 3  current FSM state (debug)
//  stat_clr      in  1  (GT_SEQ_STATS_EN) synchronous clear of link_drop_cnt
//  link_drop_cnt out 16 (GT_SEQ_STATS_EN) saturating link-loss count
module gt_link_sequencer
  import gt_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 64,
  parameter int ALIGN_TIMEOUT  = 2**22,
  parameter int UP_TIMEOUT     = 2**22,
  parameter int DROP_FILTER    = 16,
  parameter int BACKOFF_CYCLES = 2**16,
  parameter int MAX_RETRIES    = 15
) (
  input  logic        init_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  cfg_loopback,
  input  logic        rx_aligned,
  input  logic        rx_up,
  output logic        gt_rst,
  output logic [2:0]  gt_loopback,
  output logic        link_up,
  output logic        fault,
  output logic [3:0]  retry_cnt,
  output logic [2:0]  state_o
`ifdef GT_SEQ_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] link_drop_cnt
`endif
);

  // One timer serves every timed state, so it is sized for the longest interval.
  localparam int TMAX = max_int(max_int(ALIGN_TIMEOUT, UP_TIMEOUT),
                                max_int(BACKOFF_CYCLES, RST_CYCLES));
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int DW   = (DROP_FILTER > 1) ? $clog2(DROP_FILTER) : 1;

  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] ALIGN_LAST   = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [TW-1:0] UP_LAST      = TW'(UP_TIMEOUT - 1);
  localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [DW-1:0] DROP_LAST    = DW'(DROP_FILTER - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  gt_seq_state_e state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic [DW-1:0] drop_cnt;
  logic          aligned_s;
  logic          up_s;
  logic          retry_last;
  logic          loss_now;
  logic          reconfig_now;

  sync_2ff u_sync_aligned (
    .clk   (init_clk),
    .rst_n (rst_n),
    .d     (rx_aligned),
    .q     (aligned_s)
  );

  sync_2ff u_sync_up (
    .clk   (init_clk),
    .rst_n (rst_n),
    .d     (rx_up),
    .q     (up_s)
  );

  // Saturating increment: the timer parks at all-ones rather than wrapping.
  assign timer_inc    = (timer == '1) ? timer : timer + TW'(1);
  assign retry_last   = (retry_cnt + 4'd1) == RETRY_MAX;
  // Loss fires on the last of DROP_FILTER consecutive low samples of up_s.
  assign loss_now     = (state == ST_LINK_UP) && !up_s && (drop_cnt == DROP_LAST);
  assign reconfig_now = (state == ST_LINK_UP) && (cfg_loopback != gt_loopback);
  assign state_o      = state;

  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gt_rst      <= 1'b1;
      gt_loopback <= LB_NORMAL;
      link_up     <= 1'b0;
      fault       <= 1'b0;
      retry_cnt   <= 4'd0;
      timer       <= '0;
      drop_cnt    <= '0;
    end else if (!enable) begin
      // Disable overrides every other transition.
      state     <= ST_IDLE;
      gt_rst    <= 1'b1;
      link_up   <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
      timer     <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= ST_RESET;
          gt_loopback <= cfg_loopback;
          timer       <= '0;
        end

        ST_RESET: begin
          if (timer == RST_LAST) begin
            state  <= ST_WAIT_ALIGN;
            gt_rst <= 1'b0;
            timer  <= '0;
          end else begin
            timer <= timer_inc;
          end
        end

        ST_WAIT_ALIGN: begin
          if (aligned_s) begin
            state <= ST_WAIT_UP;
            timer <= '0;
          end else if (timer == ALIGN_LAST) begin
            gt_rst <= 1'b1;
            timer  <= '0;
            if (retry_last) begin
              state     <= ST_FAULT;
              fault     <= 1'b1;
              retry_cnt <= RETRY_MAX;
            end else begin
              state     <= ST_BACKOFF;
              retry_cnt <= retry_cnt + 4'd1;
            end
          end else begin
            timer <= timer_inc;
          end
        end

        ST_WAIT_UP: begin
          if (up_s) begin
            state     <= ST_LINK_UP;
            link_up   <= 1'b1;
            retry_cnt <= 4'd0;
            drop_cnt  <= '0;
          end else if (!aligned_s || timer == UP_LAST) begin
            gt_rst <= 1'b1;
            timer  <= '0;
            if (retry_last) begin
              state     <= ST_FAULT;
              fault     <= 1'b1;
              retry_cnt <= RETRY_MAX;
            end else begin
              state     <= ST_BACKOFF;
              retry_cnt <= retry_cnt + 4'd1;
            end
          end else begin
            timer <= timer_inc;
          end
        end

        ST_LINK_UP: begin
          // Loss and reconfig share one RESET entry; the new mode is always latched.
          if (loss_now || reconfig_now) begin
            state       <= ST_RESET;
            gt_rst      <= 1'b1;
            link_up     <= 1'b0;
            gt_loopback <= cfg_loopback;
            timer       <= '0;
            drop_cnt    <= '0;
          end else if (up_s) begin
            drop_cnt <= '0;
          end else begin
            drop_cnt <= drop_cnt + DW'(1);
          end
        end

        ST_BACKOFF: begin
          if (timer == BACKOFF_LAST) begin
            state       <= ST_RESET;
            gt_loopback <= cfg_loopback;
            timer       <= '0;
          end else begin
            timer <= timer_inc;
          end
        end

        ST_FAULT: begin
          gt_rst <= 1'b1;
        end

        default: begin
          state  <= ST_IDLE;
          gt_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef GT_SEQ_STATS_EN
  // Counts only genuine losses; a loss in the same cycle as enable=0 never
  // reaches RESET and is not counted.
  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      link_drop_cnt <= 16'd0;
    end else if (stat_clr) begin
      link_drop_cnt <= 16'd0;
    end else if (enable && loss_now && link_drop_cnt != 16'hFFFF) begin
      link_drop_cnt <= link_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gt_link_sequencer.sv
// Testbench: tb_gt_link_sequencer
// Directed scenarios for gt_link_sequencer with short timing parameters.
// Define GT_SEQ_STATS_EN for both RTL and bench to exercise the drop counter.
module tb_gt_link_sequencer;
  import gt_seq_pkg::*;

  logic        init_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  cfg_loopback;
  logic        rx_aligned;
  logic        rx_up;
  logic        gt_rst;
  logic [2:0]  gt_loopback;
  logic        link_up;
  logic        fault;
  logic [3:0]  retry_cnt;
  logic [2:0]  state_o;
`ifdef GT_SEQ_STATS_EN
  logic        stat_clr;
  logic [15:0] link_drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 init_clk = ~init_clk;

  gt_link_sequencer #(
    .RST_CYCLES     (8),
    .ALIGN_TIMEOUT  (32),
    .UP_TIMEOUT     (32),
    .DROP_FILTER    (4),
    .BACKOFF_CYCLES (16),
    .MAX_RETRIES    (3)
  ) dut (
    .init_clk      (init_clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_loopback  (cfg_loopback),
    .rx_aligned    (rx_aligned),
    .rx_up         (rx_up),
`ifdef GT_SEQ_STATS_EN
    .stat_clr      (stat_clr),
    .link_drop_cnt (link_drop_cnt),
`endif
    .gt_rst        (gt_rst),
    .gt_loopback   (gt_loopback),
    .link_up       (link_up),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .state_o       (state_o)
  );

  // Advance one cycle; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge init_clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    ok = (state_o === s);
  endtask

  // Counts consecutive cycles spent in state s, starting from the current one.
  task automatic count_state(input logic [2:0] s, output int n);
    n = 1;
    while (n < 200) begin
      tick();
      if (state_o !== s) break;
      n++;
    end
  endtask

  // Link partner model: aligned 10 cycles after gt_rst falls, up 5 cycles later.
  task automatic link_bring(output bit ok);
    rx_aligned = 1'b0;
    rx_up      = 1'b0;
    wait_state(ST_WAIT_ALIGN, 200, ok);
    if (!ok) return;
    repeat (9) tick();
    rx_aligned = 1'b1;
    repeat (5) tick();
    rx_up = 1'b1;
    wait_state(ST_LINK_UP, 20, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; cfg_loopback = LB_NORMAL;
    rx_aligned = 1'b0; rx_up = 1'b0;
`ifdef GT_SEQ_STATS_EN
    stat_clr = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    total++; if (gt_rst !== 1'b1) begin bad++; $display("FAIL reset_gt_rst got=%b want=1", gt_rst); end
    total++; if ({link_up, fault, gt_loopback, retry_cnt} !== 9'd0) begin bad++; $display("FAIL reset_outputs got=%b want=0", {link_up, fault, gt_loopback, retry_cnt}); end
`ifdef GT_SEQ_STATS_EN
    total++; if (link_drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", link_drop_cnt); end
`endif
    @(negedge init_clk) rst_n = 1'b1;
    repeat (3) tick();
    total++; if (state_o !== ST_IDLE || gt_rst !== 1'b1) begin bad++; $display("FAIL idle_hold got state=%0d rst=%b want state=0 rst=1", state_o, gt_rst); end
  endtask

  task automatic test_bringup();
    int  n;
    bit  rst_ok = 1'b1;
    enable = 1'b1;
    tick();
    total++; if (state_o !== ST_RESET) begin bad++; $display("FAIL bringup_enter got=%0d want=1", state_o); end
    n = 1;
    while (state_o === ST_RESET && n < 50) begin
      if (gt_rst !== 1'b1) rst_ok = 1'b0;
      tick();
      if (state_o === ST_RESET) n++;
    end
    total++; if (n != 8 || !rst_ok) begin bad++; $display("FAIL bringup_rst_len got=%0d high=%b want=8 high=1", n, rst_ok); end
    total++; if (state_o !== ST_WAIT_ALIGN || gt_rst !== 1'b0) begin bad++; $display("FAIL bringup_release got state=%0d rst=%b want state=2 rst=0", state_o, gt_rst); end
    repeat (9) tick();
    rx_aligned = 1'b1;
    repeat (2) tick();
    total++; if (state_o !== ST_WAIT_ALIGN) begin bad++; $display("FAIL bringup_sync_latency got=%0d want=2", state_o); end
    tick();
    total++; if (state_o !== ST_WAIT_UP) begin bad++; $display("FAIL bringup_wait_up got=%0d want=3", state_o); end
    repeat (2) tick();
    rx_up = 1'b1;
    repeat (2) tick();
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL bringup_early_link got=%b want=0", link_up); end
    tick();
    total++; if (link_up !== 1'b1 || state_o !== ST_LINK_UP) begin bad++; $display("FAIL bringup_link got link=%b state=%0d want link=1 state=4", link_up, state_o); end
    total++; if (retry_cnt !== 4'd0 || gt_rst !== 1'b0) begin bad++; $display("FAIL bringup_retry got retry=%0d rst=%b want 0 0", retry_cnt, gt_rst); end
  endtask

  task automatic test_no_align();
    bit ok;
    int n;
    enable = 1'b0; rx_aligned = 1'b0; rx_up = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    wait_state(ST_WAIT_ALIGN, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL noalign_reach_wait got=%0d want=2", state_o); end
    count_state(ST_WAIT_ALIGN, n);
    total++; if (n != 32) begin bad++; $display("FAIL noalign_timeout_len got=%0d want=32", n); end
    total++; if (state_o !== ST_BACKOFF || retry_cnt !== 4'd1 || gt_rst !== 1'b1) begin bad++; $display("FAIL noalign_backoff1 got state=%0d retry=%0d rst=%b want 5 1 1", state_o, retry_cnt, gt_rst); end
    count_state(ST_BACKOFF, n);
    total++; if (n != 16 || state_o !== ST_RESET) begin bad++; $display("FAIL noalign_backoff_len got=%0d next=%0d want 16 1", n, state_o); end
    wait_state(ST_BACKOFF, 100, ok);
    total++; if (!ok || retry_cnt !== 4'd2) begin bad++; $display("FAIL noalign_backoff2 got state=%0d retry=%0d want 5 2", state_o, retry_cnt); end
    wait_state(ST_FAULT, 100, ok);
    total++; if (!ok || fault !== 1'b1 || retry_cnt !== 4'd3 || gt_rst !== 1'b1) begin bad++; $display("FAIL noalign_fault got state=%0d fault=%b retry=%0d rst=%b want 6 1 3 1", state_o, fault, retry_cnt, gt_rst); end
    repeat (20) tick();
    total++; if (state_o !== ST_FAULT || gt_rst !== 1'b1 || link_up !== 1'b0) begin bad++; $display("FAIL noalign_fault_hold got state=%0d rst=%b link=%b want 6 1 0", state_o, gt_rst, link_up); end
  endtask

  task automatic test_fault_exit();
    bit ok;
    int n;
    enable = 1'b0;
    tick();
    total++; if (state_o !== ST_IDLE || fault !== 1'b0 || retry_cnt !== 4'd0) begin bad++; $display("FAIL fexit_idle got state=%0d fault=%b retry=%0d want 0 0 0", state_o, fault, retry_cnt); end
    enable = 1'b1;
    tick();
    count_state(ST_RESET, n);
    total++; if (n != 8 || state_o !== ST_WAIT_ALIGN) begin bad++; $display("FAIL fexit_reset_len got=%0d next=%0d want 8 2", n, state_o); end
    wait_state(ST_BACKOFF, 50, ok);
    total++; if (!ok || retry_cnt !== 4'd1) begin bad++; $display("FAIL fexit_retry1 got state=%0d retry=%0d want 5 1", state_o, retry_cnt); end
    link_bring(ok);
    total++; if (!ok || retry_cnt !== 4'd0) begin bad++; $display("FAIL fexit_retry_clear got state=%0d retry=%0d want 4 0", state_o, retry_cnt); end
  endtask

  task automatic test_drop_filter();
    bit stayed = 1'b1;
    rx_up = 1'b0;
    repeat (3) tick();
    rx_up = 1'b1;
    repeat (6) begin
      tick();
      if (link_up !== 1'b1) stayed = 1'b0;
    end
    total++; if (!stayed) begin bad++; $display("FAIL drop_glitch got link drop want link held"); end
    rx_up = 1'b0;
    repeat (4) tick();
    rx_up = 1'b1;
    tick();
    total++; if (link_up !== 1'b1) begin bad++; $display("FAIL drop_boundary got=%b want=1", link_up); end
    tick();
    total++; if (state_o !== ST_RESET || link_up !== 1'b0 || gt_rst !== 1'b1 || retry_cnt !== 4'd0) begin bad++; $display("FAIL drop_loss got state=%0d link=%b rst=%b retry=%0d want 1 0 1 0", state_o, link_up, gt_rst, retry_cnt); end
`ifdef GT_SEQ_STATS_EN
    total++; if (link_drop_cnt !== 16'd1) begin bad++; $display("FAIL drop_stat got=%0d want=1", link_drop_cnt); end
`endif
  endtask

  task automatic test_reconfig();
    bit ok;
    link_bring(ok);
    total++; if (!ok) begin bad++; $display("FAIL reconfig_link got=%0d want=4", state_o); end
    cfg_loopback = LB_NEAR_PMA;
    tick();
    total++; if (state_o !== ST_RESET || gt_loopback !== LB_NEAR_PMA || link_up !== 1'b0) begin bad++; $display("FAIL reconfig_reset got state=%0d lb=%b link=%b want 1 010 0", state_o, gt_loopback, link_up); end
`ifdef GT_SEQ_STATS_EN
    total++; if (link_drop_cnt !== 16'd1) begin bad++; $display("FAIL reconfig_stat got=%0d want=1", link_drop_cnt); end
`endif
    cfg_loopback = LB_FAR_PMA;
    tick();
    total++; if (gt_loopback !== LB_NEAR_PMA) begin bad++; $display("FAIL reconfig_ignored got=%b want=010", gt_loopback); end
    cfg_loopback = LB_NEAR_PMA;
  endtask

  task automatic test_async_reset();
    bit ok;
    rx_aligned = 1'b0; rx_up = 1'b0;
    wait_state(ST_WAIT_ALIGN, 50, ok);
    repeat (2) tick();
    rx_aligned = 1'b1;
    wait_state(ST_WAIT_UP, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_reach got=%0d want=3", state_o); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (state_o !== ST_IDLE || gt_rst !== 1'b1 || gt_loopback !== 3'b000) begin bad++; $display("FAIL areset_state got state=%0d rst=%b lb=%b want 0 1 000", state_o, gt_rst, gt_loopback); end
    total++; if ({link_up, fault, retry_cnt} !== 6'd0) begin bad++; $display("FAIL areset_outputs got=%b want=0", {link_up, fault, retry_cnt}); end
    rx_aligned = 1'b0;
    @(negedge init_clk) rst_n = 1'b1;
  endtask

  task automatic test_disable();
    bit ok;
    link_bring(ok);
    total++; if (!ok) begin bad++; $display("FAIL disable_link got=%0d want=4", state_o); end
    enable = 1'b0;
    tick();
    total++; if (state_o !== ST_IDLE || link_up !== 1'b0 || gt_rst !== 1'b1) begin bad++; $display("FAIL disable_idle got state=%0d link=%b rst=%b want 0 0 1", state_o, link_up, gt_rst); end
    enable = 1'b1;
  endtask

`ifdef GT_SEQ_STATS_EN
  task automatic test_stats();
    bit ok;
    for (int i = 0; i < 2; i++) begin
      link_bring(ok);
      total++; if (!ok) begin bad++; $display("FAIL stats_link%0d got=%0d want=4", i, state_o); end
      rx_up = 1'b0;
      repeat (6) tick();
    end
    total++; if (link_drop_cnt !== 16'd2) begin bad++; $display("FAIL stats_two got=%0d want=2", link_drop_cnt); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    total++; if (link_drop_cnt !== 16'd0) begin bad++; $display("FAIL stats_clr got=%0d want=0", link_drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_no_align();
    test_fault_exit();
    test_drop_filter();
    test_reconfig();
    test_async_reset();
`ifdef GT_SEQ_STATS_EN
    test_stats();
`endif
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
